breathing_fib_pwm_multi: RTL and testbench

Multi-channel breathing PWM generator. Each channel's HIGH and LOW phase lengths step through the Fibonacci sequence, producing a smooth "breathing" LED drive. This is the parametrised successor of the single-channel 8-bit Fibonacci PWM. It adds configurable counter width, N independent channels, a mirrored (rise-then-fall) breathing mode besides wrap-around, a synchronous restart, and per-channel status pulses. It sits between the LED/GPIO pad drivers and the control register block.

---
 rtl/breathing_fib_pkg.sv | 14 +
 rtl/breathing_fib_channel.sv | 113 +++++++++++
 rtl/breathing_fib_pwm_multi.sv | 40 ++++
 tb/tb_breathing_fib_pwm_multi.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/breathing_fib_pkg.sv
// Shared types for the Fibonacci breathing PWM: phase, direction, mode and per-channel control state.
package breathing_fib_pkg;

  typedef enum logic {PH_HIGH = 1'b0, PH_LOW = 1'b1} phase_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_MIRROR = 1'b1} mode_e;

  // Width-independent part of a channel's state; the WIDTH-sized counters live in the channel.
  typedef struct packed {
    phase_e phase;
    dir_e   dir;
  } fib_chan_state_t;

endpackage

// File: rtl/breathing_fib_channel.sv
// One breathing PWM channel: HIGH/LOW phases of length cur, with cur walking the Fibonacci
// sequence up (and, in mirror mode, back down) at each LOW phase end.
module breathing_fib_channel
  import breathing_fib_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_PERIOD = (2 ** WIDTH) - 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  input  logic i_en,
  input  logic i_mode,
  output logic o_pwm,
  output logic o_peak,
  output logic o_cycle_done
);

  localparam logic [WIDTH-1:0] One  = WIDTH'(1);
  localparam logic [WIDTH:0]   MaxP = (WIDTH + 1)'(MAX_PERIOD);

  logic [WIDTH-1:0] r_cnt, r_cur, r_prv;
  logic [WIDTH-1:0] w_cnt_d, w_cur_d, w_prv_d;
  fib_chan_state_t  r_st, w_st_d;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_end, w_ovf;
  mode_e            w_mode;
  logic             w_peak_evt, w_done_evt;
  logic             r_peak_evt, r_done_evt;
  logic             r_pwm, r_peak, r_done;

  assign w_mode = mode_e'(i_mode);
  assign w_sum  = {1'b0, r_cur} + {1'b0, r_prv};
  assign w_diff = r_cur - r_prv;
  assign w_ovf  = (w_sum > MaxP);
  assign w_end  = (r_cnt == (r_cur - One));

  always_comb begin
    w_cnt_d    = r_cnt;
    w_cur_d    = r_cur;
    w_prv_d    = r_prv;
    w_st_d     = r_st;
    w_peak_evt = 1'b0;
    w_done_evt = 1'b0;
    if (i_en) begin
      if (!w_end) begin
        w_cnt_d = r_cnt + One;
      end else begin
        w_cnt_d = '0;
        if (r_st.phase == PH_HIGH) begin
          w_st_d.phase = PH_LOW;
        end else begin
          w_st_d.phase = PH_HIGH;
          if (r_st.dir == DIR_UP) begin
            if (!w_ovf) begin
              w_cur_d = w_sum[WIDTH-1:0];
              w_prv_d = r_cur;
            end else if (w_mode == MODE_WRAP) begin
              w_cur_d    = One;
              w_prv_d    = '0;
              w_done_evt = 1'b1;
            end else begin
              w_st_d.dir = DIR_DOWN;
              w_cur_d    = r_prv;
              w_prv_d    = w_diff;
              w_peak_evt = 1'b1;
            end
          end else if ((r_cur == One) && (r_prv == '0)) begin
            w_st_d.dir = DIR_UP;
            w_cur_d    = One;
            w_prv_d    = One;
            w_done_evt = 1'b1;
          end else begin
            w_cur_d = r_prv;
            w_prv_d = w_diff;
          end
        end
      end
    end
  end

  // Status pulses pass through a staging flop so they line up with the first pwm cycle of
  // the HIGH phase they announce (pwm itself lags the phase register by one cycle).
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      r_cnt      <= '0;
      r_cur      <= One;
      r_prv      <= '0;
      r_st       <= '{phase: PH_HIGH, dir: DIR_UP};
      r_peak_evt <= 1'b0;
      r_done_evt <= 1'b0;
      r_pwm      <= 1'b0;
      r_peak     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_d;
      r_cur      <= w_cur_d;
      r_prv      <= w_prv_d;
      r_st       <= w_st_d;
      r_peak_evt <= w_peak_evt;
      r_done_evt <= w_done_evt;
      r_pwm      <= i_en & (r_st.phase == PH_HIGH);
      r_peak     <= r_peak_evt;
      r_done     <= r_done_evt;
    end
  end

  assign o_pwm        = r_pwm;
  assign o_peak       = r_peak;
  assign o_cycle_done = r_done;

endmodule

// File: rtl/breathing_fib_pwm_multi.sv
// Multi-channel Fibonacci breathing PWM: NUM_CH independent channels sharing clock, reset,
// restart and the wrap/mirror mode select.
module breathing_fib_pwm_multi
  import breathing_fib_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned MAX_PERIOD = (2 ** WIDTH) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              mode,
  input  logic              restart,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] peak,
  output logic [NUM_CH-1:0] cycle_done
);

  if ((MAX_PERIOD < 2) || (64'(MAX_PERIOD) > ((64'(1) << WIDTH) - 64'(1)))) begin : g_bad_max
    $error("MAX_PERIOD must lie in 2..2**WIDTH-1");
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    breathing_fib_channel #(
      .WIDTH      (WIDTH),
      .MAX_PERIOD (MAX_PERIOD)
    ) u_ch (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_restart    (restart),
      .i_en         (en[k]),
      .i_mode       (mode),
      .o_pwm        (pwm_out[k]),
      .o_peak       (peak[k]),
      .o_cycle_done (cycle_done[k])
    );
  end

endmodule

// File: tb/tb_breathing_fib_pwm_multi.sv
// Scoreboard bench: a Fibonacci-index model predicts each cycle's outputs; a monitor compares.
module tb_breathing_fib_pwm_multi;

  localparam int unsigned MaxA = 8;
  localparam int unsigned MaxB = 255;

  logic       clk = 1'b0;
  logic       rst, restart, mode_a;
  logic [3:0] en_a;
  logic [0:0] en_b;
  logic [3:0] pwm_a, peak_a, done_a;
  logic [0:0] pwm_b, peak_b, done_b;

  always #5 clk = ~clk;

  breathing_fib_pwm_multi #(.WIDTH(8), .NUM_CH(4), .MAX_PERIOD(MaxA)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .restart(restart),
    .pwm_out(pwm_a), .peak(peak_a), .cycle_done(done_a)
  );

  breathing_fib_pwm_multi #(.WIDTH(8), .NUM_CH(1), .MAX_PERIOD(MaxB)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(1'b0), .restart(1'b0),
    .pwm_out(pwm_b), .peak(peak_b), .cycle_done(done_b)
  );

  typedef struct packed {
    logic [4:0] pwm;
    logic [4:0] pk;
    logic [4:0] dn;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Model: channel c sits at Fibonacci index idx (cur=fib[idx], prv=fib[idx-1]).
  int fib[0:24];
  int idx[5], rem[5];
  bit high[5], down[5], pend_pk[5], pend_dn[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset(input int c);
    idx[c] = 1; rem[c] = 1; high[c] = 1; down[c] = 0; pend_pk[c] = 0; pend_dn[c] = 0;
  endtask

  task automatic model_step(input int c, input bit mirror, input int mx);
    rem[c]--;
    if (rem[c] == 0) begin
      if (high[c]) begin
        high[c] = 0;
      end else begin
        high[c] = 1;
        if (!down[c]) begin
          if (fib[idx[c] + 1] <= mx) idx[c]++;
          else if (!mirror) begin idx[c] = 1; pend_dn[c] = 1; end
          else begin down[c] = 1; idx[c]--; pend_pk[c] = 1; end
        end else if (idx[c] > 1) begin
          idx[c]--;
        end else begin
          idx[c] = 2; down[c] = 0; pend_dn[c] = 1;
        end
      end
      rem[c] = fib[idx[c]];
    end
  endtask

  // Predict outputs after the coming posedge from current inputs, then advance the model.
  task automatic cyc();
    exp_t e;
    e = '0;
    for (int c = 0; c < 5; c++) begin
      bit r, en_c, md;
      int mx;
      r    = rst || ((c < 4) && restart);
      en_c = (c < 4) ? en_a[c] : en_b[0];
      md   = (c < 4) ? mode_a : 1'b0;
      mx   = (c < 4) ? MaxA : MaxB;
      if (r) begin
        model_reset(c);
      end else begin
        e.pwm[c] = en_c & high[c];
        e.pk[c]  = pend_pk[c];
        e.dn[c]  = pend_dn[c];
        pend_pk[c] = 0;
        pend_dn[c] = 0;
        if (en_c) model_step(c, md, mx);
      end
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor plus run-length tracking on the 255-period instance.
  int run_b = 0, last_b = 0, max_b = 0, after_max_b = -1;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("pwm_out", {27'd0, pwm_b, pwm_a}, {27'd0, e.pwm});
      check("peak", {27'd0, peak_b, peak_a}, {27'd0, e.pk});
      check("cycle_done", {27'd0, done_b, done_a}, {27'd0, e.dn});
    end
    if (pwm_b[0] === 1'b1) begin
      run_b++;
    end else if (run_b > 0) begin
      if ((last_b == 233) && (after_max_b < 0)) after_max_b = run_b;
      if (run_b > max_b) max_b = run_b;
      last_b = run_b;
      run_b  = 0;
    end
  end

  initial begin
    bit found;
    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i < 25; i++) fib[i] = fib[i-1] + fib[i-2];
    for (int c = 0; c < 5; c++) model_reset(c);

    rst = 1; restart = 0; mode_a = 1; en_a = '0; en_b = '0;
    cyc(); cyc();
    rst = 0;

    // Mirror breathing on channel 0; instance B starts its long wrap run.
    en_a = 4'b0001; en_b = 1'b1;
    repeat (80) cyc();

    // Wrap breathing on channel 0.
    restart = 1; cyc(); restart = 0;
    mode_a = 0;
    repeat (60) cyc();

    // Disable at cnt=3 of the 5-cycle HIGH phase, hold 10 cycles, resume.
    restart = 1; cyc(); restart = 0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (high[0] && (fib[idx[0]] == 5) && (rem[0] == 2)) found = 1;
      else cyc();
    end
    check("t4_reach", 32'(found), 32'd1);
    en_a = 4'b0000;
    repeat (10) cyc();
    en_a = 4'b0001;
    repeat (20) cyc();

    // Restart during mirror descent, on a cycle where channel 0 ends a phase.
    restart = 1; cyc(); restart = 0;
    mode_a = 1; en_a = 4'b1111;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (down[0] && (rem[0] == 1)) found = 1;
      else cyc();
    end
    check("t5_reach", 32'(found), 32'd1);
    restart = 1; cyc(); restart = 0;
    repeat (12) cyc();

    // Staggered enables on channels 1 and 3 only.
    restart = 1; cyc(); restart = 0;
    en_a = 4'b0000;
    repeat (5) cyc();
    en_a = 4'b0010;
    repeat (7) cyc();
    en_a = 4'b1010;
    repeat (100) cyc();

    // Random enables, mode flips and sparse restarts.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en_a = 4'($urandom);
      if ($urandom_range(0, 49) == 0) mode_a = 1'($urandom);
      restart = ($urandom_range(0, 149) == 0);
      cyc();
    end
    restart = 0;
    repeat (3) cyc();
    repeat (2) @(posedge clk);
    #2;

    check("q_drained", 32'(q.size()), 32'd0);
    check("b_longest_phase", 32'(max_b), 32'd233);
    check("b_phase_after_233", 32'(after_max_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
